// File: rtl/map_pkg.sv
// rtl/map_pkg.sv - shared constants, sprite codes and FSM state type for the map access arbiter
package map_pkg;

    localparam int MAP_W_DEF = 20;
    localparam int MAP_H_DEF = 25;
    localparam int ADDR_W    = 9;
    localparam int CODE_W    = 3;

    localparam logic [CODE_W-1:0] SPR_EMPTY  = 3'd0;
    localparam logic [CODE_W-1:0] SPR_WALL   = 3'd1;
    localparam logic [CODE_W-1:0] SPR_DOT    = 3'd2;
    localparam logic [CODE_W-1:0] SPR_POWER  = 3'd3;
    localparam logic [CODE_W-1:0] SPR_PACMAN = 3'd4;
    localparam logic [CODE_W-1:0] SPR_GHOST  = 3'd5;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } arb_state_t;

endpackage

// File: rtl/map_req_picker.sv
// rtl/map_req_picker.sv - combinational request picker: req vector (plus pointer) to one-hot grant and index
//
// Ports:
//   req    in   per-requester request bits
//   ptr    in   last granted index (present only with MAP_ARB_ROUND_ROBIN_EN)
//   grant  out  one-hot winner
//   idx    out  binary index of the winner
//   any    out  some requester won
// Macro MAP_ARB_ROUND_ROBIN_EN selects cyclic search after ptr; otherwise
// fixed priority with index 0 highest.
module map_req_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
`ifdef MAP_ARB_ROUND_ROBIN_EN
    input  logic [IDX_W-1:0]   ptr,
`endif
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

`ifdef MAP_ARB_ROUND_ROBIN_EN
    always_comb begin
        int cand;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        // Start one past the last winner so the last winner is searched last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
            end
        end
    end
`else
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && req[i]) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/map_access_arbiter.sv
// rtl/map_access_arbiter.sv - shares the single-port map RAM among requesters and runs the clear sweep
//
// Ports:
//   clock_50, reset_n            clock and synchronous active-low reset
//   req/req_we/req_x/req_y/req_wdata  packed per-requester access (5-bit x/y, 3-bit data)
//   grant                        one-hot, combinational, in the accept cycle
//   rdata_valid/rdata            registered read response one cycle after grant
//   oob_err                      accepted access had x >= MAP_W or y >= MAP_H
//   clear_start/busy/clear_done  clear sweep control and status
//   ram_address/ram_data/ram_wren/ram_q  map RAM port (q valid 1 cycle after address)
// Macro MAP_ARB_ROUND_ROBIN_EN enables round-robin arbitration (default fixed priority).
module map_access_arbiter
    import map_pkg::*;
#(
    parameter int          NUM_REQ     = 3,
    parameter int          MAP_W       = MAP_W_DEF,
    parameter int          MAP_H       = MAP_H_DEF,
    parameter logic [2:0]  CLEAR_VALUE = 3'd0
) (
    input  logic                   clock_50,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_we,
    input  logic [5*NUM_REQ-1:0]   req_x,
    input  logic [5*NUM_REQ-1:0]   req_y,
    input  logic [3*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     rdata_valid,
    output logic [2:0]             rdata,
    output logic                   oob_err,
    input  logic                   clear_start,
    output logic                   busy,
    output logic                   clear_done,
    output logic [8:0]             ram_address,
    output logic [2:0]             ram_data,
    output logic                   ram_wren,
    input  logic [2:0]             ram_q
);

    localparam int         IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [8:0] MAP_W9    = 9'(MAP_W);
    localparam logic [8:0] MAP_H9    = 9'(MAP_H);
    localparam logic [8:0] LAST_ADDR = 9'(MAP_W * MAP_H - 1);

    arb_state_t           state_q, state_d;
    logic [8:0]           clr_cnt_q;
    logic [NUM_REQ-1:0]   rvalid_q;
    logic                 roob_q;
    logic                 clear_done_q;
    logic                 accept;

    logic [NUM_REQ-1:0]   pick_grant;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;

    logic [4:0]           sel_x, sel_y;
    logic [2:0]           sel_wdata;
    logic                 sel_we, sel_oob;
    logic [8:0]           lin_addr;

`ifdef MAP_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]     ptr_q;
`endif

    map_req_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req   (req),
`ifdef MAP_ARB_ROUND_ROBIN_EN
        .ptr   (ptr_q),
`endif
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign sel_x     = req_x[5*pick_idx +: 5];
    assign sel_y     = req_y[5*pick_idx +: 5];
    assign sel_wdata = req_wdata[3*pick_idx +: 3];
    assign sel_we    = req_we[pick_idx];
    assign sel_oob   = ({4'b0, sel_x} >= MAP_W9) || ({4'b0, sel_y} >= MAP_H9);
    // Product wraps to 9 bits; only matters for out-of-range accesses, which never write.
    assign lin_addr  = {4'b0, sel_y} * MAP_W9 + {4'b0, sel_x};

    always_comb begin
        state_d     = state_q;
        grant       = '0;
        accept      = 1'b0;
        oob_err     = 1'b0;
        ram_address = '0;
        ram_data    = '0;
        ram_wren    = 1'b0;
        case (state_q)
            IDLE: begin
                // clear_start outranks every requester in the same cycle
                if (clear_start) begin
                    state_d = CLEAR;
                end else if (pick_any) begin
                    accept      = 1'b1;
                    grant       = pick_grant;
                    oob_err     = sel_oob;
                    ram_address = lin_addr;
                    ram_data    = sel_wdata;
                    ram_wren    = sel_we && !sel_oob;
                end
            end
            CLEAR: begin
                ram_address = clr_cnt_q;
                ram_data    = CLEAR_VALUE;
                ram_wren    = 1'b1;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                end
            end
        endcase
        // Keep the RAM and requesters quiet while reset is held.
        if (!reset_n) begin
            grant    = '0;
            accept   = 1'b0;
            oob_err  = 1'b0;
            ram_wren = 1'b0;
        end
    end

    always_ff @(posedge clock_50) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            clr_cnt_q    <= '0;
            rvalid_q     <= '0;
            roob_q       <= 1'b0;
            clear_done_q <= 1'b0;
`ifdef MAP_ARB_ROUND_ROBIN_EN
            ptr_q        <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= (state_q == CLEAR) ? clr_cnt_q + 9'd1 : 9'd0;
            clear_done_q <= (state_q == CLEAR) && (clr_cnt_q == LAST_ADDR);
            rvalid_q     <= (accept && !sel_we) ? pick_grant : '0;
            roob_q       <= accept && sel_oob;
`ifdef MAP_ARB_ROUND_ROBIN_EN
            if (accept) begin
                ptr_q <= pick_idx;
            end
`endif
        end
    end

    assign busy        = (state_q == CLEAR);
    assign clear_done  = clear_done_q;
    assign rdata_valid = rvalid_q;
    assign rdata       = ((|rvalid_q) && !roob_q) ? ram_q : 3'd0;

endmodule
